// File: rtl/div_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_req_if
//   Request/writeback bundle between the core's M-extension path and
//   div_issue_ctrl.
//   master (core)       : drives in_valid/in_op/in_rs1/in_rs2/in_rd,
//                         samples res_valid/res_data/res_rd
//   slave (issue ctrl)  : the reverse
//   in_op encoding: 0=DIV, 1=DIVU, 2=REM, 3=REMU
// ---------------------------------------------------------------------------
interface div_req_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic [1:0]       in_op;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [TAG_W-1:0] in_rd;

    logic             res_valid;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_rd;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd,
        input  res_valid, res_data, res_rd
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd,
        output res_valid, res_data, res_rd
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//   Issue/writeback controller around a LATENCY-stage pipelined unsigned
//   divider that has no valid, no metadata and no stall. Signed operands are
//   turned into magnitudes on the way in; a parallel metadata pipe tracks
//   each op so the quotient/remainder can be sign-corrected and selected on
//   the way out. The result is registered, giving LATENCY+1 cycles of
//   request-to-writeback latency at one op per cycle, in order.
//
//   clk, rst          : clock, synchronous active-high reset
//   req (slave)       : request in / writeback out (see div_req_if)
//   flush             : kill every in-flight op and any same-cycle request
//   div_dividend/_divisor  : operands to the divider
//   div_quotient/_remainder: divider outputs, LATENCY cycles later
//   pending_mask      : bit r set while an op with rd=r is in flight
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int LATENCY = 7,
    parameter int TAG_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    div_req_if.slave    req,
    input  logic        flush,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic [31:0] pending_mask
);
    typedef struct packed {
        logic             valid;
        logic             is_rem;
        logic             neg_q;
        logic             neg_r;
        logic [TAG_W-1:0] rd;
    } meta_t;

    meta_t [LATENCY-1:0] meta_q, meta_d;
    meta_t               meta_in;

    logic             res_valid_q;
    logic [31:0]      res_data_q, res_data_d;
    logic [TAG_W-1:0] res_rd_q;

    logic        is_signed;
    logic [31:0] q_fix, r_fix;
    meta_t       meta_out;

    // Operand conditioning. Negating 0x80000000 yields 0x80000000, which is
    // exactly the magnitude the unsigned divider needs.
    assign is_signed    = ~req.in_op[0];
    assign div_dividend = (is_signed && req.in_rs1[31]) ? -req.in_rs1 : req.in_rs1;
    assign div_divisor  = (is_signed && req.in_rs2[31]) ? -req.in_rs2 : req.in_rs2;

    always_comb begin
        meta_in        = '0;
        meta_in.valid  = req.in_valid & ~flush & (req.in_rd != '0);
        meta_in.is_rem = req.in_op[1];
        // Divide-by-zero must return all ones, so never negate that quotient.
        meta_in.neg_q  = is_signed & (req.in_rs1[31] ^ req.in_rs2[31]) & (req.in_rs2 != '0);
        meta_in.neg_r  = is_signed & req.in_rs1[31];
        meta_in.rd     = req.in_rd;
    end

    // Unconditional shift; flush only drops the valids, the divider's stale
    // data keeps flowing and comes out unqualified.
    always_comb begin
        meta_d    = meta_q;
        meta_d[0] = meta_in;
        for (int i = 1; i < LATENCY; i++) begin
            meta_d[i]       = meta_q[i-1];
            meta_d[i].valid = meta_q[i-1].valid & ~flush;
        end
    end

    // Sign/select fixup on the entry aligned with the divider output.
    assign meta_out = meta_q[LATENCY-1];
    assign q_fix    = meta_out.neg_q ? -div_quotient  : div_quotient;
    assign r_fix    = meta_out.neg_r ? -div_remainder : div_remainder;
    assign res_data_d = meta_out.is_rem ? r_fix : q_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
        end else begin
            meta_q      <= meta_d;
            res_valid_q <= meta_out.valid & ~flush;
            res_data_q  <= res_data_d;
            res_rd_q    <= meta_out.rd;
        end
    end

    assign req.res_valid = res_valid_q;
    assign req.res_data  = res_data_q;
    assign req.res_rd    = res_rd_q;

    // Hazard mask covers the whole pipe plus the output register, i.e. every
    // op whose writeback has not yet been seen by the register file.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < LATENCY; i++) begin
            if (meta_q[i].valid)
                pending_mask = pending_mask | (32'(1) << meta_q[i].rd);
        end
        if (res_valid_q)
            pending_mask = pending_mask | (32'(1) << res_rd_q);
        pending_mask[0] = 1'b0;
    end
endmodule
